// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;

  localparam logic [PC_W-1:0]    DEF_PC_STEP   = 16'd4;
  localparam logic [INSTR_W-1:0] DEF_NOP_INSTR = 16'h0000;

  // IDLE: no request. WAIT: request outstanding. HOLD: instruction presented.
  // DROP: a redirect orphaned the outstanding request; swallow its response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  // 16-bit modulo PC advance; wraps silently.
  function automatic logic [PC_W-1:0] pc_advance(input logic [PC_W-1:0] pc,
                                                 input logic [PC_W-1:0] step);
    return pc + step;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory request/response bus: one request outstanding at a time.
interface fetch_stage_if;
  import if_pkg::*;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  // Fetch side issues requests, memory side answers them.
  modport master (output imem_req, output imem_addr,
                  input  imem_rvalid, input imem_rdata);
  modport slave  (input  imem_req, input imem_addr,
                  output imem_rvalid, output imem_rdata);

endinterface

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register: redirect load beats sequential increment.
module pc_reg
  import if_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
  parameter logic [PC_W-1:0] PC_STEP  = DEF_PC_STEP
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            inc,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q, pc_d;

  // Next PC: branch target has priority over +PC_STEP.
  always_comb begin
    pc_d = pc_q;
    if (load)     pc_d = target;
    else if (inc) pc_d = pc_advance(pc_q, PC_STEP);
  end

  // PC state with synchronous reset to RESET_PC.
  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, runs the imem handshake and drives IF/ID.
module fetch_stage
  import if_pkg::*;
#(
  parameter logic [PC_W-1:0]    RESET_PC  = 16'h0000,
  parameter logic [PC_W-1:0]    PC_STEP   = DEF_PC_STEP,
  parameter logic [INSTR_W-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  fetch_stage_if.master      imem,
  output logic               valid_out,
  output logic [PC_W-1:0]    pc_out,
  output logic [PC_W-1:0]    pc_plus4_out,
  output logic [INSTR_W-1:0] instruction_out
);

  fetch_state_t       state_q, state_d;
  logic               req_q, req_d;
  logic               valid_q, valid_d;
  logic [PC_W-1:0]    pc_out_q, pc_out_d;
  logic [PC_W-1:0]    pc4_q, pc4_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               pc_load, pc_inc;
  logic [PC_W-1:0]    pc;

  pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk    (clk),
    .reset  (reset),
    .load   (pc_load),
    .inc    (pc_inc),
    .target (branch_target),
    .pc     (pc)
  );

  // Next state and next output values; redirect overrides stall and rvalid.
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    pc_out_d = pc_out_q;
    pc4_d    = pc4_q;
    instr_d  = instr_q;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    if (branch_taken) begin
      pc_load = 1'b1;
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      case (state_q)
        // A response arriving with the redirect is dropped on the spot; a
        // response still in flight must be swallowed in DROP.
        WAIT:    state_d = imem.imem_rvalid ? WAIT : DROP;
        DROP:    state_d = DROP;
        default: state_d = WAIT;
      endcase
    end else begin
      case (state_q)
        IDLE: state_d = WAIT;
        WAIT: begin
          if (imem.imem_rvalid) begin
            valid_d  = 1'b1;
            instr_d  = imem.imem_rdata;
            pc_out_d = pc;
            pc4_d    = pc_advance(pc, PC_STEP);
            pc_inc   = 1'b1;
            state_d  = HOLD;
          end
        end
        HOLD: begin
          // IF/ID captures at this edge; present a bubble until the next fetch.
          if (!stall) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            state_d = WAIT;
          end
        end
        DROP: if (imem.imem_rvalid) state_d = WAIT;
        default: state_d = IDLE;
      endcase
    end
    req_d = (state_d == WAIT);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      pc_out_q <= '0;
      pc4_q    <= '0;
      instr_q  <= NOP_INSTR;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
      pc_out_q <= pc_out_d;
      pc4_q    <= pc4_d;
      instr_q  <= instr_d;
    end
  end

  // PC only moves on a response or a redirect, so the address holds while requesting.
  assign imem.imem_req   = req_q;
  assign imem.imem_addr  = pc;
  assign valid_out       = valid_q;
  assign pc_out          = pc_out_q;
  assign pc_plus4_out    = pc4_q;
  assign instruction_out = instr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-programmable memory model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken;
  logic [15:0] branch_target;
  logic        valid_out, valid2;
  logic [15:0] pc_out, pc_plus4_out, instruction_out;
  logic [15:0] pc2, pc4_2, instr2;

  int n_chk  = 0;
  int n_pass = 0;
  int lat    = 1;
  logic spur = 1'b0;

  fetch_stage_if imem_bus ();
  fetch_stage_if imem_bus2 ();

  fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .imem            (imem_bus),
    .valid_out       (valid_out),
    .pc_out          (pc_out),
    .pc_plus4_out    (pc_plus4_out),
    .instruction_out (instruction_out)
  );

  // Second instance exercises PC wrap from a non-zero reset vector.
  fetch_stage #(.RESET_PC(16'hFFFC)) dut2 (
    .clk             (clk),
    .reset           (reset),
    .stall           (1'b0),
    .branch_taken    (1'b0),
    .branch_target   (16'h0000),
    .imem            (imem_bus2),
    .valid_out       (valid2),
    .pc_out          (pc2),
    .pc_plus4_out    (pc4_2),
    .instruction_out (instr2)
  );

  assign imem_bus2.imem_rvalid = imem_bus2.imem_req;
  assign imem_bus2.imem_rdata  = 16'hB000;

  always #5 clk = ~clk;

  // Memory model: response in the lat-th cycle after the request starts;
  // an orphaned request still completes after req drops.
  logic        pend = 1'b0;
  int          cnt  = 0;
  logic [15:0] txn_addr = '0;
  logic        mem_active;
  logic [15:0] cur_addr;

  function automatic logic [15:0] mem_data(input logic [15:0] a);
    return 16'hA001 + {2'b00, a[15:2]};
  endfunction

  assign mem_active = !reset && (imem_bus.imem_req || pend);
  assign cur_addr   = pend ? txn_addr : imem_bus.imem_addr;
  assign imem_bus.imem_rvalid = (mem_active && (cnt == lat - 1)) || spur;
  assign imem_bus.imem_rdata  = imem_bus.imem_rvalid ? mem_data(cur_addr) : 16'hDEAD;

  always @(posedge clk) begin
    if (reset || imem_bus.imem_rvalid) begin
      pend <= 1'b0;
      cnt  <= 0;
    end else if (mem_active) begin
      pend <= 1'b1;
      cnt  <= cnt + 1;
      if (!pend) txn_addr <= imem_bus.imem_addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int n = 0;
    while (valid_out !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_arrive"}, {31'd0, valid_out}, 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, {31'd0, valid_out}, 32'd0);
    chk({tag, "_pc"},    {16'd0, pc_out}, 32'h0);
    chk({tag, "_pc4"},   {16'd0, pc_plus4_out}, 32'h0);
    chk({tag, "_instr"}, {16'd0, instruction_out}, 32'h0);
    chk({tag, "_req"},   {31'd0, imem_bus.imem_req}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    step(); step();
    chk_reset_vals("rst");
    chk("rst2_pc", {16'd0, pc2}, 32'h0);
    reset = 1'b0;

    // Sequential fetch, 1-cycle memory.
    step();
    chk("seq_req0",  {31'd0, imem_bus.imem_req}, 32'd1);
    chk("seq_addr0", {16'd0, imem_bus.imem_addr}, 32'h0000);
    chk("wrap_addr0", {16'd0, imem_bus2.imem_addr}, 32'hFFFC);
    step();
    chk("seq_v0",   {31'd0, valid_out}, 32'd1);
    chk("seq_pc0",  {16'd0, pc_out}, 32'h0000);
    chk("seq_pc40", {16'd0, pc_plus4_out}, 32'h0004);
    chk("seq_i0",   {16'd0, instruction_out}, 32'hA001);
    chk("wrap_pc",  {16'd0, pc2}, 32'hFFFC);
    chk("wrap_pc4", {16'd0, pc4_2}, 32'h0000);
    chk("wrap_i",   {16'd0, instr2}, 32'hB000);
    step();
    chk("bub_v",     {31'd0, valid_out}, 32'd0);
    chk("bub_i",     {16'd0, instruction_out}, 32'h0000);
    chk("bub_pc",    {16'd0, pc_out}, 32'h0000);
    chk("seq_addr1", {16'd0, imem_bus.imem_addr}, 32'h0004);
    chk("wrap_req1", {31'd0, imem_bus2.imem_req}, 32'd1);
    chk("wrap_addr1", {16'd0, imem_bus2.imem_addr}, 32'h0000);
    step();
    chk("seq_pc1",  {16'd0, pc_out}, 32'h0004);
    chk("seq_pc41", {16'd0, pc_plus4_out}, 32'h0008);
    chk("seq_i1",   {16'd0, instruction_out}, 32'hA002);

    // Stall holds the presented instruction; a stray rvalid is ignored.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) spur = 1'b1;
      step();
      spur = 1'b0;
      chk("stall_v",   {31'd0, valid_out}, 32'd1);
      chk("stall_pc",  {16'd0, pc_out}, 32'h0004);
      chk("stall_i",   {16'd0, instruction_out}, 32'hA002);
      chk("stall_req", {31'd0, imem_bus.imem_req}, 32'd0);
    end
    stall = 1'b0;
    lat   = 3;
    step();
    chk("stall_addr", {16'd0, imem_bus.imem_addr}, 32'h0008);
    chk("stall_req2", {31'd0, imem_bus.imem_req}, 32'd1);
    chk("bub2_pc",    {16'd0, pc_out}, 32'h0004);

    // Redirect while waiting: orphaned response dropped.
    branch_taken = 1'b1; branch_target = 16'h0100;
    step();
    branch_taken = 1'b0;
    chk("drop_req", {31'd0, imem_bus.imem_req}, 32'd0);
    chk("drop_v",   {31'd0, valid_out}, 32'd0);
    step();
    chk("drop_rv",  {31'd0, imem_bus.imem_rvalid}, 32'd1);
    step();
    chk("drop_v2",   {31'd0, valid_out}, 32'd0);
    chk("drop_i",    {16'd0, instruction_out}, 32'h0000);
    chk("br_addr",   {16'd0, imem_bus.imem_addr}, 32'h0100);
    chk("br_req",    {31'd0, imem_bus.imem_req}, 32'd1);
    wait_valid(10, "br");
    chk("br_pc",  {16'd0, pc_out}, 32'h0100);
    chk("br_pc4", {16'd0, pc_plus4_out}, 32'h0104);
    chk("br_i",   {16'd0, instruction_out}, 32'hA041);

    // Redirect coincident with rvalid: data discarded.
    lat = 1;
    step();
    chk("co_addr0", {16'd0, imem_bus.imem_addr}, 32'h0104);
    branch_taken = 1'b1; branch_target = 16'h0200;
    step();
    branch_taken = 1'b0;
    chk("co_v",    {31'd0, valid_out}, 32'd0);
    chk("co_i",    {16'd0, instruction_out}, 32'h0000);
    chk("co_pc",   {16'd0, pc_out}, 32'h0100);
    chk("co_req",  {31'd0, imem_bus.imem_req}, 32'd1);
    chk("co_addr", {16'd0, imem_bus.imem_addr}, 32'h0200);
    step();
    chk("co_v2", {31'd0, valid_out}, 32'd1);
    chk("co_pc2", {16'd0, pc_out}, 32'h0200);
    chk("co_i2", {16'd0, instruction_out}, 32'hA081);

    // Reset mid-transaction with slow memory.
    lat = 3;
    step();
    chk("mr_addr", {16'd0, imem_bus.imem_addr}, 32'h0204);
    step();
    reset = 1'b1;
    step();
    chk_reset_vals("mr");
    reset = 1'b0;
    step();
    chk("mr_req2",  {31'd0, imem_bus.imem_req}, 32'd1);
    chk("mr_addr2", {16'd0, imem_bus.imem_addr}, 32'h0000);
    wait_valid(10, "mr");
    chk("mr_pc", {16'd0, pc_out}, 32'h0000);
    chk("mr_i",  {16'd0, instruction_out}, 32'hA001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
